mc_controller: RTL

- Multicycle main controller FSM that sequences the shared 32-bit MIPS datapath (PC register, regfile, ALU, immext, unified memory) across several cycles per instruction.
- Decodes opcode/funct from the instruction register and drives every datapath select, write-enable and ALU control.
- Handshakes with a unified instruction/data memory that may stall.
- Sits beside the datapath inside the core top level, replacing the single-cycle decoder.

---
 rtl/mc_pkg.sv | 83 ++++++++
 rtl/mc_if.sv | 37 +++
 rtl/mc_aludec.sv | 25 ++
 rtl/mc_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller, ALU and immediate extender.
package mc_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUCTL_W  = 4;
  localparam int unsigned IMMTYPE_W = 2;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [IMMTYPE_W-1:0] IMM_SIGN  = 2'b00;
  localparam logic [IMMTYPE_W-1:0] IMM_ZERO  = 2'b01;
  localparam logic [IMMTYPE_W-1:0] IMM_SETHI = 2'b10;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic [IMMTYPE_W-1:0] immtype;
    logic [ALUCTL_W-1:0]  alucontrol;
  } imm_ctrl_t;

  // Immediate-class opcode -> extender mode and ALU operation.
  function automatic imm_ctrl_t imm_decode(input logic [OP_W-1:0] op);
    imm_ctrl_t c;
    c.immtype    = IMM_SIGN;
    c.alucontrol = ALU_ADD;
    case (op)
      OP_ANDI: begin c.immtype = IMM_ZERO;  c.alucontrol = ALU_AND; end
      OP_ORI:  begin c.immtype = IMM_ZERO;  c.alucontrol = ALU_OR;  end
      OP_LUI:  begin c.immtype = IMM_SETHI; c.alucontrol = ALU_ADD; end
      default: begin c.immtype = IMM_SIGN;  c.alucontrol = ALU_ADD; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory signal bundle.
interface mc_if;
  import mc_pkg::*;

  logic [OP_W-1:0]      op;
  logic [FUNCT_W-1:0]   funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 memwrite;
  logic                 iord;
  logic                 irwrite;
  logic                 pcen;
  logic [SEL_W-1:0]     pcsrc;
  logic                 alusrca;
  logic [SEL_W-1:0]     alusrcb;
  logic [IMMTYPE_W-1:0] immtype;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic [ALUCTL_W-1:0]  alucontrol;
  logic                 illegal;
  logic [STATE_W-1:0]   state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           immtype, regdst, memtoreg, regwrite, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           immtype, regdst, memtoreg, regwrite, alucontrol, illegal, state
  );

endinterface

// File: rtl/mc_aludec.sv
// R-type funct -> ALU control decoder with a valid flag for unsupported functs.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alucontrol_c,
  output logic                valid_c
);

  // Map each supported funct to its ALU operation.
  always_comb begin
    alucontrol_c = ALU_ADD;
    valid_c      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol_c = ALU_ADD;
      FN_SUB:  alucontrol_c = ALU_SUB;
      FN_AND:  alucontrol_c = ALU_AND;
      FN_OR:   alucontrol_c = ALU_OR;
      FN_SLT:  alucontrol_c = ALU_SLT;
      FN_NOR:  alucontrol_c = ALU_NOR;
      default: valid_c      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback.
module mc_controller
  import mc_pkg::*;
#(
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
)(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t              state_q;
  state_t              state_d;
  logic                illegal_q;
  logic                set_illegal;
  logic [ALUCTL_W-1:0] rt_alucontrol;
  logic                rt_valid;
  imm_ctrl_t           imm_ctrl;

  mc_aludec u_aludec (
    .funct        (bus.funct),
    .alucontrol_c (rt_alucontrol),
    .valid_c      (rt_valid)
  );

  assign imm_ctrl    = imm_decode(bus.op);
  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Sticky unsupported-instruction flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end

  // Next-state and datapath control decode. Memory requests are gated by
  // reset so an in-flight access drops immediately, and mem_ready only
  // counts while a request is actually up.
  always_comb begin
    state_d        = state_q;
    set_illegal    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
    bus.pcsrc      = PCSRC_ALU;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_B;
    bus.immtype    = IMM_SIGN;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alucontrol = ALU_ADD;

    case (state_q)
      FETCH: begin
        bus.mem_req = reset;
        bus.alusrcb = SRCB_FOUR;
        bus.irwrite = bus.mem_ready & reset;
        bus.pcen    = bus.mem_ready & reset;
        if (bus.mem_ready) state_d = DECODE;
      end

      DECODE: begin
        bus.alusrcb = SRCB_IMMSH;
        case (bus.op)
          OP_LW, OP_SW:                       state_d = MEMADR;
          OP_RTYPE:                           state_d = RTYPEEX;
          OP_BEQ, OP_BNE:                     state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:   state_d = IMMEX;
          OP_J:                               state_d = JUMP;
          default: begin
            state_d     = FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        state_d     = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        bus.mem_req = reset;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end

      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = FETCH;
      end

      MEMWR: begin
        bus.mem_req  = reset;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end

      RTYPEEX: begin
        bus.alusrca = 1'b1;
        if (rt_valid) begin
          bus.alucontrol = rt_alucontrol;
          state_d        = RTYPEWB;
        end else begin
          set_illegal = 1'b1;
          state_d     = FETCH;
        end
      end

      RTYPEWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = FETCH;
      end

      BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = PCSRC_ALUOUT;
        bus.pcen       = (bus.op == OP_BEQ) ? bus.zero : ~bus.zero;
        state_d        = FETCH;
      end

      IMMEX: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = SRCB_IMM;
        bus.immtype    = imm_ctrl.immtype;
        bus.alucontrol = imm_ctrl.alucontrol;
        state_d        = IMMWB;
      end

      IMMWB: begin
        // Keep extender/ALU settings so ALUOut stays stable during writeback.
        bus.immtype    = imm_ctrl.immtype;
        bus.alucontrol = imm_ctrl.alucontrol;
        bus.regwrite   = 1'b1;
        state_d        = FETCH;
      end

      JUMP: begin
        bus.pcsrc = PCSRC_JUMP;
        bus.pcen  = 1'b1;
        state_d   = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

endmodule
